// File: rtl/demux_stream_1ton.sv
// demux_stream_1ton: registered 1-to-N valid/ready stream demultiplexer.
// Modes: addressed (in_sel), broadcast (all-or-nothing), round-robin (rr_ptr).
// Ports: clk, rst (async, active-high); mode[1:0];
//   in_valid/in_ready/in_data[DATA_W]/in_sel[SEL_W] from the producer;
//   out_valid[N]/out_ready[N]/out_data[N*DATA_W] to the consumers,
//   where channel k sits on out_data[k*DATA_W +: DATA_W];
//   rr_ptr[SEL_W] is the next round-robin target;
//   xfer_count[CNT_W] counts accepted words and saturates at all-ones.
module demux_stream_1ton #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16,
  localparam int N     = 2**SEL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]    in_sel,
  output logic [N-1:0]        out_valid,
  input  logic [N-1:0]        out_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]    rr_ptr,
  output logic [CNT_W-1:0]    xfer_count
);

  localparam logic [1:0] M_ADDR = 2'b00;
  localparam logic [1:0] M_BCST = 2'b01;
  localparam logic [1:0] M_RR   = 2'b10;

  logic [N-1:0] free;
  logic [N-1:0] tgt;
  logic [N-1:0] load;
  logic         rdy;
  logic         accept;

  // A slot can take a word if it is empty or drains this cycle.
  assign free = ~out_valid | out_ready;

  always_comb begin
    rdy = 1'b0;
    tgt = '0;
    unique case (mode)
      M_ADDR: begin
        rdy         = free[in_sel];
        tgt[in_sel] = 1'b1;
      end
      M_BCST: begin
        rdy = &free;
        tgt = {N{1'b1}};
      end
      M_RR: begin
        rdy         = free[rr_ptr];
        tgt[rr_ptr] = 1'b1;
      end
      default: begin
        rdy = 1'b0;
        tgt = '0;
      end
    endcase
  end

  // Held low during reset so nothing is accepted into a slot
  // that is being cleared.
  assign in_ready = rdy & ~rst;
  assign accept   = in_valid & in_ready;
  assign load     = accept ? tgt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        // Reload beats drain: valid stays set, data replaced.
        if (load[k]) begin
          out_valid[k]                   <= 1'b1;
          out_data[k*DATA_W +: DATA_W]   <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && mode == M_RR) begin
      // N is a power of two, so natural overflow wraps N-1 -> 0.
      rr_ptr <= rr_ptr + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (accept && xfer_count != {CNT_W{1'b1}}) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// tb_demux_stream_1ton: directed bench with per-channel scoreboard queues.
// Runs DATA_W=8, SEL_W=3, CNT_W=2 so counter saturation is reachable.
module tb_demux_stream_1ton;

  localparam int DW = 8;
  localparam int SW = 3;
  localparam int CW = 2;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_sel;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [N*DW-1:0] out_data;
  logic [SW-1:0] rr_ptr;
  logic [CW-1:0] xfer_count;

  demux_stream_1ton #(
    .DATA_W(DW),
    .SEL_W (SW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rr_ptr    (rr_ptr),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[N][$];
  logic [N-1:0]  mvalid;
  logic [SW-1:0] mrr;
  logic [CW-1:0] mcnt;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ch(input int k);
    return out_data[k*DW +: DW];
  endfunction

  task automatic model_clear();
    mvalid = '0;
    mrr    = '0;
    mcnt   = '0;
    for (int k = 0; k < N; k++) q[k].delete();
  endtask

  // One clock: compare against the model at the negedge, apply the
  // cycle's handshakes to the model, return at posedge + 1.
  task automatic tick();
    logic [N-1:0] fr;
    logic [N-1:0] ld;
    logic         mr;
    @(negedge clk);
    fr = ~mvalid | out_ready;
    ld = '0;
    mr = 1'b0;
    case (mode)
      2'b00: begin mr = fr[in_sel]; ld[in_sel] = 1'b1; end
      2'b01: begin mr = &fr; ld = '1; end
      2'b10: begin mr = fr[mrr]; ld[mrr] = 1'b1; end
      default: mr = 1'b0;
    endcase
    chk("in_ready", 64'(in_ready), 64'(mr));
    chk("out_valid", 64'(out_valid), 64'(mvalid));
    chk("rr_ptr", 64'(rr_ptr), 64'(mrr));
    chk("xfer_count", 64'(xfer_count), 64'(mcnt));
    for (int k = 0; k < N; k++) begin
      if (mvalid[k] && out_ready[k]) begin
        if (q[k].size() == 0) chk("sb_empty", 64'(1), 64'(0));
        else chk($sformatf("sb_ch%0d", k), 64'(ch(k)), 64'(q[k].pop_front()));
      end
    end
    if (in_valid && mr) begin
      for (int k = 0; k < N; k++) if (ld[k]) q[k].push_back(in_data);
      if (mode == 2'b10) mrr = mrr + 3'd1;
      if (mcnt != 2'b11) mcnt = mcnt + 2'd1;
    end else begin
      ld = '0;
    end
    mvalid = ld | (mvalid & ~out_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_rr", 64'(rr_ptr), 64'(0));
    chk("rst_cnt", 64'(xfer_count), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 64'(out_valid), 64'(0));
    chk("rst_hold_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 2'b00;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '0;
    model_clear();
    #1;
    chk("por_valid", 64'(out_valid), 64'(0));
    chk("por_data", 64'(out_data), 64'(0));
    chk("por_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: fill three slots, then reset mid-stream
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_sel  = SW'(i);
      in_data = DW'(8'hD0 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("t1_full", 64'(out_valid), 64'(8'b0000_1110));
    in_valid  = 1'b1;
    out_ready = '1;
    do_reset();
    in_valid = 1'b0;
    tick();

    // 2: addressed
    mode     = 2'b00;
    in_valid = 1'b1;
    in_sel   = 3'd5;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("t2_valid", 64'(out_valid), 64'(8'b0010_0000));
    chk("t2_ch5", 64'(ch(5)), 64'(8'hA5));
    out_ready = 8'hDF;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    #1;
    chk("t2_stall_ready", 64'(in_ready), 64'(0));
    tick();
    chk("t2_hold_ch5", 64'(ch(5)), 64'(8'hA5));
    chk("t2_hold_valid", 64'(out_valid), 64'(8'b0010_0000));
    in_valid  = 1'b0;
    out_ready = '1;
    tick();

    // 3: broadcast
    do_reset();
    mode     = 2'b01;
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick();
    in_valid = 1'b0;
    chk("t3_valid", 64'(out_valid), 64'(8'hFF));
    chk("t3_data", 64'(out_data), {8{8'h11}});
    out_ready = 8'hFB;
    in_valid  = 1'b1;
    in_data   = 8'h22;
    #1;
    chk("t3_stall_ready", 64'(in_ready), 64'(0));
    tick();
    chk("t3_only_ch2", 64'(out_valid), 64'(8'h04));
    chk("t3_cnt", 64'(xfer_count), 64'(1));
    tick();
    out_ready = '1;
    tick();
    in_valid = 1'b0;
    chk("t3_bcast2", 64'(out_data), {8{8'h22}});
    tick();

    // 4: round-robin
    do_reset();
    mode     = 2'b10;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DW'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("t4_rr", 64'(rr_ptr), 64'(2));
    chk("t4_last_valid", 64'(out_valid), 64'(8'h02));
    chk("t4_last_ch1", 64'(ch(1)), 64'(9));
    mode      = 2'b00;
    in_sel    = 3'd2;
    out_ready = 8'hFB;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    tick();
    chk("t4_rr_addr", 64'(rr_ptr), 64'(2));
    mode    = 2'b10;
    in_data = 8'h66;
    #1;
    chk("t4_stall_ready", 64'(in_ready), 64'(0));
    tick();
    tick();
    chk("t4_rr_hold", 64'(rr_ptr), 64'(2));
    in_valid  = 1'b0;
    out_ready = '1;
    tick();

    // 5: reload during drain, one word per cycle
    mode     = 2'b00;
    in_sel   = 3'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = DW'(8'h80 + i);
      tick();
      chk("t5_valid3", 64'(out_valid[3]), 64'(1));
      chk("t5_ch3", 64'(ch(3)), 64'(8'h80 + i));
    end
    in_valid = 1'b0;
    tick();

    // 6: reserved mode, then counter saturation
    out_ready = 8'hBF;
    in_sel    = 3'd6;
    in_valid  = 1'b1;
    in_data   = 8'h66;
    tick();
    mode    = 2'b11;
    in_data = 8'h77;
    #1;
    chk("t6_ready", 64'(in_ready), 64'(0));
    tick();
    tick();
    chk("t6_valid", 64'(out_valid), 64'(8'h40));
    chk("t6_ch6", 64'(ch(6)), 64'(8'h66));
    in_valid  = 1'b0;
    out_ready = '1;
    tick();
    do_reset();
    mode     = 2'b00;
    in_sel   = 3'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = DW'(8'h40 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("t6_cnt_sat", 64'(xfer_count), 64'(3));
    tick();
    tick();
    for (int k = 0; k < N; k++)
      chk($sformatf("sb_left_ch%0d", k), 64'(q[k].size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
